// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: single-entry registered binary-to-one-hot decoder with valid/ready handshake.
// Optional macro: DEC_RANGE_ERR_EN enables the sticky out-of-range err flag (otherwise err is tied to 0).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - input handshake carrying in_sel [SEL_W-1:0]
//   flush                 - discard pending output, block input this cycle
//   out_valid/out_ready   - output handshake carrying out_onehot [NUM_OUT-1:0]
//   err, err_clr          - sticky out-of-range flag and its clear
module onehot_decoder_pipe #(
    parameter int SEL_W   = 4,
    parameter int NUM_OUT = 16,
    parameter int HOLD    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic               err,
    input  logic               err_clr
);
    logic               out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0] out_onehot_q, out_onehot_d;
    logic [NUM_OUT-1:0] dec;
    logic               accept;

    // Ready depends only on state, flush and out_ready, never on in_valid.
    assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec = '0;
        // Codes at or above NUM_OUT match no bit and decode to an all-zero word.
        for (int i = 0; i < NUM_OUT; i++)
            dec[i] = (in_sel == SEL_W'(i));
        out_valid_d  = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        out_onehot_d = accept ? dec : (!out_valid_d && HOLD == 0) ? '0 : out_onehot_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;

`ifdef DEC_RANGE_ERR_EN
    logic err_q, err_d;
    logic oor;

    assign oor = accept && (int'(in_sel) >= NUM_OUT);

    // A new out-of-range accept takes priority over a simultaneous clear.
    always_comb err_d = oor ? 1'b1 : err_clr ? 1'b0 : err_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb_onehot_decoder_pipe: table-driven check of two decoder instances (16-way HOLD=0, 10-way HOLD=1).
module tb_onehot_decoder_pipe;
`ifdef DEC_RANGE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [3:0]  sel;
        logic        flush;
        logic        out_ready;
        logic        err_clr;
        logic        ready;
        logic        valid;
        logic [15:0] oh0;
        logic [9:0]  oh1;
        logic        err1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_sel = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        in_ready0, out_valid0, err0;
    logic        in_ready1, out_valid1, err1;
    logic [15:0] out_onehot0;
    logic [9:0]  out_onehot1;
    int          checks = 0;
    int          errors = 0;
    vec_t        v[$];

    always #5 clk = ~clk;

    onehot_decoder_pipe #(.SEL_W(4), .NUM_OUT(16), .HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sel(in_sel), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .out_onehot(out_onehot0), .err(err0), .err_clr(err_clr)
    );

    onehot_decoder_pipe #(.SEL_W(4), .NUM_OUT(10), .HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sel(in_sel), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .out_onehot(out_onehot1), .err(err1), .err_clr(err_clr)
    );

    task automatic chk(input int step, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [3:0] s, input logic fl,
                       input logic ordy, input logic ec, input logic rdy, input logic vl,
                       input logic [15:0] o0, input logic [9:0] o1, input logic e1);
        vec_t t;
        t.rst_n = r; t.in_valid = iv; t.sel = s; t.flush = fl; t.out_ready = ordy;
        t.err_clr = ec; t.ready = rdy; t.valid = vl; t.oh0 = o0; t.oh1 = o1; t.err1 = e1;
        v.push_back(t);
    endtask

    initial begin
        logic seen;
        // reset held with idle inputs
        add(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 10'h000, 0);
        // back-to-back sel 0..15, first accept on the edge right after reset release
        seen = 1'b0;
        for (int s = 0; s < 16; s++) begin
            seen = seen | (s >= 10);
            add(1, 1, 4'(s), 0, 1, 0, 1, 1, 16'(1) << s, (s < 10) ? 10'(1) << s : 10'h000, ERR_EN & seen);
        end
        // drain and clear err; dut1 holds its last word (zero from sel 15)
        add(1, 0, 0, 0, 1, 1, 1, 0, 16'h0000, 10'h000, 0);
        // backpressure: 5 pending, 9 waits three cycles, then 5 out / 9 in together
        add(1, 1, 5, 0, 0, 0, 1, 1, 16'h0020, 10'h020, 0);
        for (int k = 0; k < 3; k++)
            add(1, 1, 9, 0, 0, 0, 0, 1, 16'h0020, 10'h020, 0);
        add(1, 1, 9, 0, 1, 0, 1, 1, 16'h0200, 10'h200, 0);
        add(1, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 10'h200, 0);
        // flush over pending 3 with in_valid sel 2
        add(1, 1, 3, 0, 0, 0, 1, 1, 16'h0008, 10'h008, 0);
        add(1, 1, 2, 1, 1, 0, 0, 0, 16'h0000, 10'h008, 0);
        add(1, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 10'h008, 0);
        // out-of-range for the 10-way instance: zero-word transaction
        add(1, 1, 12, 0, 0, 0, 1, 1, 16'h1000, 10'h000, ERR_EN);
        add(1, 0, 0, 0, 1, 1, 1, 0, 16'h0000, 10'h000, 0);
        // set beats simultaneous clear, then err stays sticky
        add(1, 1, 11, 0, 1, 1, 1, 1, 16'h0800, 10'h000, ERR_EN);
        add(1, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 10'h000, ERR_EN);
        // reset while a result is pending and err set, then accept 3 on the first edge
        add(1, 1, 7, 0, 0, 0, 1, 1, 16'h0080, 10'h080, ERR_EN);
        add(0, 1, 4, 0, 1, 0, 0, 0, 16'h0000, 10'h000, 0);
        add(1, 1, 3, 0, 1, 0, 1, 1, 16'h0008, 10'h008, 0);
        add(1, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 10'h008, 0);

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            rst_n = v[i].rst_n; in_valid = v[i].in_valid; in_sel = v[i].sel;
            flush = v[i].flush; out_ready = v[i].out_ready; err_clr = v[i].err_clr;
            #1;
            chk(i, "in_ready0", 32'(in_ready0), 32'(v[i].ready));
            chk(i, "in_ready1", 32'(in_ready1), 32'(v[i].ready));
            @(posedge clk);
            #1;
            chk(i, "out_valid0", 32'(out_valid0), 32'(v[i].valid));
            chk(i, "out_valid1", 32'(out_valid1), 32'(v[i].valid));
            chk(i, "out_onehot0", 32'(out_onehot0), 32'(v[i].oh0));
            chk(i, "out_onehot1", 32'(out_onehot1), 32'(v[i].oh1));
            chk(i, "err0", 32'(err0), 32'(0));
            chk(i, "err1", 32'(err1), 32'(v[i].err1));
            chk(i, "onehot1_bits", 32'($countones(out_onehot1) <= 1), 32'(1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_pipe.md
ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 4: select code width in bits, legal range 1..8.
REQ-002 SHALL have parameter NUM_OUT, default 16: number of one-hot outputs, legal range 2..2**SEL_W.
REQ-003 SHALL have parameter HOLD, default 0: 1 keeps the last one-hot word on out_onehot while idle; 0 drives zero while idle.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1: in_sel is valid this cycle.
REQ-007 SHALL have port in_ready  output  1: block accepts in_sel this cycle.
REQ-008 SHALL have port in_sel  input  SEL_W: binary select code.
REQ-009 SHALL have port flush  input  1: synchronous discard of the pending output.
REQ-010 SHALL have port out_valid  output  1: out_onehot holds a decoded result.
REQ-011 SHALL have port out_ready  input  1: consumer takes the result this cycle.
REQ-012 SHALL have port out_onehot  output  NUM_OUT: registered decode result.
REQ-013 SHALL have port err  output  1: sticky out-of-range flag.
REQ-014 SHALL have port err_clr  input  1: clears err.

Function
REQ-015 SHALL be a single-entry pipeline register: accept occurs when in_valid && in_ready, transfer when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !flush && (!out_valid || out_ready): full throughput, one accept per cycle, no combinational path from in_valid to in_ready.
REQ-017 SHALL, on accept, set out_valid in the next cycle and load out_onehot with bit in_sel set and all other bits clear; latency is exactly 1 cycle.
REQ-018 SHALL, on accept with in_sel >= NUM_OUT, load out_onehot with all zeros and still assert out_valid, so an invalid code produces a zero-word transaction rather than being dropped.
REQ-019 SHALL hold out_valid and out_onehot stable while out_valid && !out_ready (backpressure).
REQ-020 SHALL clear out_valid after a transfer that has no accept in the same cycle; on a simultaneous transfer and accept, it SHALL load the new result with out_valid staying 1.
REQ-021 SHALL, with HOLD=0, force out_onehot to zero whenever out_valid is 0; with HOLD=1, out_onehot keeps the last loaded word while idle.
REQ-022 SHALL, on flush, clear out_valid next cycle and accept no input that cycle; with HOLD=0 out_onehot goes to zero, with HOLD=1 it keeps its value; flush overrides simultaneous in_valid and out_ready.
REQ-023 SHALL never assert more than one bit of out_onehot.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set out_valid=0, out_onehot=0 and err=0 regardless of HOLD, flush or any handshake in flight; in_ready SHALL read 0 while rst_n=0.
REQ-025 SHALL accept input on the first edge after rst_n returns to 1, provided in_valid=1.

Configuration
REQ-026 SHALL support macro DEC_RANGE_ERR_EN: when defined, err sets on the edge after an accept with in_sel >= NUM_OUT and stays set until err_clr=1 or reset; set wins over a simultaneous err_clr.
REQ-027 SHALL, when DEC_RANGE_ERR_EN is undefined, tie err to constant 0, ignore err_clr, and leave all other behaviour unchanged.

Verification
REQ-028 SHALL pass test 1: SEL_W=4, NUM_OUT=16, out_ready=1, in_sel=0..15 back-to-back -> out_onehot = 16'h0001..16'h8000 each one cycle later; out_valid stays high continuously.
REQ-029 SHALL pass test 2: accept in_sel=5, then hold out_ready=0 for 3 cycles while in_valid=1, in_sel=9 -> in_ready=0, out_onehot=16'h0020 stable; on the release cycle 5 transfers and 9 is accepted; next cycle 16'h0200.
REQ-030 SHALL pass test 3: NUM_OUT=10, DEC_RANGE_ERR_EN defined, in_sel=12 -> out_valid=1 with out_onehot=0, err=1 next cycle; err_clr=1 for one cycle -> err=0.
REQ-031 SHALL pass test 4: pending result 16'h0008 with out_ready=0; flush=1 with in_valid=1, in_sel=2 -> next cycle out_valid=0; HOLD=0 gives out_onehot=0, HOLD=1 gives 16'h0008; sel 2 is not accepted.
REQ-032 SHALL pass test 5: rst_n=0 for one edge while a result is pending and err=1 -> out_valid=0, out_onehot=0, err=0; in_sel=3 accepted on the first edge after release -> 16'h0008.
REQ-033 SHALL pass test 6: DEC_RANGE_ERR_EN undefined, in_sel >= NUM_OUT -> err stays 0 and the zero-word transaction still occurs.
